// File: rtl/simple_cpu_pkg.sv
// Shared constants, field positions and FSM state type for the simple_cpu
// instruction fetch path.
package simple_cpu_pkg;

    localparam int INSTR_WIDTH = 20;
    localparam int ADDR_BITS   = 5;

    localparam logic [INSTR_WIDTH-1:0] HALT_WORD = '0;

    // Instruction field positions
    localparam int TYPE_MSB   = 19;
    localparam int TYPE_LSB   = 18;
    localparam int X1_MSB     = 17;
    localparam int X1_LSB     = 12;
    localparam int X2_MSB     = 11;
    localparam int X2_LSB     = 6;
    localparam int X3_MSB     = 5;
    localparam int X3_LSB     = 0;
    localparam int ALU_OP_BIT = 0;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        ISSUE,
        WAIT,
        HALT
    } fetch_state_t;

endpackage

// File: rtl/instr_mem.sv
// Program memory: synchronous write, synchronous read, one-cycle read latency.
// Ports: clk, we/waddr/wdata (write), re/raddr/rdata (read). No reset.
module instr_mem #(
    parameter int WIDTH = 20,
    parameter int ABITS = 5
) (
    input  logic             clk,
    input  logic             we,
    input  logic [ABITS-1:0] waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic             re,
    input  logic [ABITS-1:0] raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem [2**ABITS];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch FSM: reads program memory, hands words to the CPU, waits for retire.
// Ports: clk, rst (async low), start, prog_*, instruction/instr_valid/instr_done, pc, busy, halted.
module instr_fetch_unit #(
    parameter int INSTR_WIDTH = simple_cpu_pkg::INSTR_WIDTH,
    parameter int ADDR_BITS   = simple_cpu_pkg::ADDR_BITS
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic                   prog_we,
    input  logic [ADDR_BITS-1:0]   prog_addr,
    input  logic [INSTR_WIDTH-1:0] prog_data,
    output logic [INSTR_WIDTH-1:0] instruction,
    output logic                   instr_valid,
    input  logic                   instr_done,
    output logic [ADDR_BITS-1:0]   pc,
    output logic                   busy,
    output logic                   halted
);

    import simple_cpu_pkg::*;

    localparam logic [INSTR_WIDTH-1:0] HALT_W = INSTR_WIDTH'(HALT_WORD);

    fetch_state_t           state;
    logic                   mem_we;
    logic                   mem_re;
    logic [INSTR_WIDTH-1:0] rdata;

    // Program writes only land while the CPU is not being fed
    assign mem_we = prog_we && (state == IDLE || state == HALT);
    assign mem_re = (state == FETCH);

    instr_mem #(
        .WIDTH (INSTR_WIDTH),
        .ABITS (ADDR_BITS)
    ) u_mem (
        .clk   (clk),
        .we    (mem_we),
        .waddr (prog_addr),
        .wdata (prog_data),
        .re    (mem_re),
        .raddr (pc),
        .rdata (rdata)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            pc          <= '0;
            instruction <= '0;
            instr_valid <= 1'b0;
            busy        <= 1'b0;
            halted      <= 1'b0;
        end else begin
            unique case (state)
                IDLE, HALT: begin
                    if (start) begin
                        state  <= FETCH;
                        pc     <= '0;
                        busy   <= 1'b1;
                        halted <= 1'b0;
                    end
                end
                FETCH: begin
                    state <= ISSUE;
                end
                ISSUE: begin
                    if (rdata == HALT_W) begin
                        state  <= HALT;
                        busy   <= 1'b0;
                        halted <= 1'b1;
                    end else begin
                        instruction <= rdata;
                        instr_valid <= 1'b1;
                        state       <= WAIT;
                    end
                end
                WAIT: begin
                    if (instr_done) begin
                        instr_valid <= 1'b0;
                        // Last address ends the program instead of wrapping
                        if (pc == '1) begin
                            state  <= HALT;
                            busy   <= 1'b0;
                            halted <= 1'b1;
                        end else begin
                            pc    <= pc + ADDR_BITS'(1);
                            state <= FETCH;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Self-checking bench for instr_fetch_unit against a program-level model.
// Model: words issue in address order until a zero word or address 31.
module tb_instr_fetch_unit;

    logic        clk;
    logic        rst;
    logic        start;
    logic        prog_we;
    logic [4:0]  prog_addr;
    logic [19:0] prog_data;
    logic [19:0] instruction;
    logic        instr_valid;
    logic        instr_done;
    logic [4:0]  pc;
    logic        busy;
    logic        halted;

    int errors = 0;
    int checks = 0;

    logic [19:0] ref_mem [32];

    instr_fetch_unit dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .prog_we     (prog_we),
        .prog_addr   (prog_addr),
        .prog_data   (prog_data),
        .instruction (instruction),
        .instr_valid (instr_valid),
        .instr_done  (instr_done),
        .pc          (pc),
        .busy        (busy),
        .halted      (halted)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic prog_write(input logic [4:0] a, input logic [19:0] d);
        @(negedge clk);
        prog_we   = 1'b1;
        prog_addr = a;
        prog_data = d;
        ref_mem[a] = d;
        @(negedge clk);
        prog_we = 1'b0;
    endtask

    // Runs the loaded program from address 0. hold<0 means random done delay.
    task automatic run_program(input int hold, input int bw_k,
                               input int abort_k, output int hs);
        int k;
        int d;
        bit fin;
        hs  = 0;
        k   = 0;
        fin = 0;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int it = 0; it < 40 && !fin; it++) begin
            @(negedge clk);
            checks++;
            if (instr_valid !== 1'b0 || busy !== 1'b1) begin
                errors++;
                $display("FAIL lat_e1 k=%0d: valid=%b busy=%b want 0 1",
                         k, instr_valid, busy);
            end
            @(negedge clk);
            if (ref_mem[k] == 20'h0) begin
                checks++;
                if (halted !== 1'b1 || instr_valid !== 1'b0 ||
                    busy !== 1'b0 || pc !== 5'(k)) begin
                    errors++;
                    $display("FAIL halt_zero: halted=%b valid=%b busy=%b pc=%0d want 1 0 0 %0d",
                             halted, instr_valid, busy, pc, k);
                end
                fin = 1;
            end else begin
                checks++;
                if (instr_valid !== 1'b1 || instruction !== ref_mem[k] ||
                    pc !== 5'(k)) begin
                    errors++;
                    $display("FAIL issue k=%0d: valid=%b instr=%h pc=%0d want 1 %h %0d",
                             k, instr_valid, instruction, pc, ref_mem[k], k);
                end
                hs++;
                if (k == abort_k) begin
                    #2 rst = 1'b0;
                    #1;
                    checks++;
                    if (instr_valid !== 1'b0 || instruction !== 20'h0 ||
                        pc !== 5'd0 || busy !== 1'b0 || halted !== 1'b0) begin
                        errors++;
                        $display("FAIL async_rst: valid=%b instr=%h pc=%0d busy=%b halted=%b want all 0",
                                 instr_valid, instruction, pc, busy, halted);
                    end
                    @(negedge clk);
                    rst = 1'b1;
                    return;
                end
                d = (hold < 0) ? $urandom_range(0, 4) : hold;
                for (int i = 0; i < d; i++) begin
                    if (k == bw_k && i == 0) begin
                        prog_we   = 1'b1;
                        prog_addr = 5'd1;
                        prog_data = 20'hDC1E0;
                    end
                    if (i == 1) prog_we = 1'b0;
                    if (d >= 10 && i == 2) start = 1'b1;
                    if (i == 5) start = 1'b0;
                    @(negedge clk);
                    checks++;
                    if (instr_valid !== 1'b1 || instruction !== ref_mem[k] ||
                        pc !== 5'(k) || busy !== 1'b1) begin
                        errors++;
                        $display("FAIL hold k=%0d i=%0d: valid=%b instr=%h pc=%0d want 1 %h %0d",
                                 k, i, instr_valid, instruction, pc, ref_mem[k], k);
                    end
                end
                prog_we = 1'b0;
                start   = 1'b0;
                instr_done = 1'b1;
                @(negedge clk);
                instr_done = 1'b0;
                checks++;
                if (instr_valid !== 1'b0) begin
                    errors++;
                    $display("FAIL done_clr k=%0d: valid=%b want 0", k, instr_valid);
                end
                if (k == 31) begin
                    checks++;
                    if (halted !== 1'b1 || pc !== 5'd31 || busy !== 1'b0) begin
                        errors++;
                        $display("FAIL end31: halted=%b pc=%0d busy=%b want 1 31 0",
                                 halted, pc, busy);
                    end
                    fin = 1;
                end else begin
                    k++;
                end
            end
        end
        checks++;
        if (!fin) begin
            errors++;
            $display("FAIL run_bound: program did not finish, got k=%0d want finish", k);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        #2 rst = 1'b0;
        #2;
        checks++;
        if (instr_valid !== 1'b0 || instruction !== 20'h0 || pc !== 5'd0 ||
            busy !== 1'b0 || halted !== 1'b0) begin
            errors++;
            $display("FAIL reset: valid=%b instr=%h pc=%0d busy=%b halted=%b want all 0",
                     instr_valid, instruction, pc, busy, halted);
        end
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        instr_done = 1'b1;
        @(negedge clk);
        instr_done = 1'b0;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || halted !== 1'b0 || instr_valid !== 1'b0 ||
            pc !== 5'd0) begin
            errors++;
            $display("FAIL idle_done: busy=%b halted=%b valid=%b pc=%0d want 0 0 0 0",
                     busy, halted, instr_valid, pc);
        end
    endtask

    task automatic test_basic();
        int hs;
        prog_write(5'd0, 20'h47000);
        prog_write(5'd1, 20'h53000);
        prog_write(5'd2, 20'h00000);
        run_program(3, -1, -1, hs);
        checks++;
        if (hs != 2) begin
            errors++;
            $display("FAIL basic_hs: got %0d want 2", hs);
        end
        @(negedge clk);
        instr_done = 1'b1;
        @(negedge clk);
        instr_done = 1'b0;
        @(negedge clk);
        checks++;
        if (halted !== 1'b1 || pc !== 5'd2 || instr_valid !== 1'b0 ||
            instruction !== 20'h53000) begin
            errors++;
            $display("FAIL halt_done: halted=%b pc=%0d valid=%b instr=%h want 1 2 0 53000",
                     halted, pc, instr_valid, instruction);
        end
    endtask

    task automatic test_stall();
        int hs;
        run_program(20, -1, -1, hs);
        checks++;
        if (hs != 2) begin
            errors++;
            $display("FAIL stall_hs: got %0d want 2", hs);
        end
    endtask

    task automatic test_busy_write();
        int hs;
        prog_write(5'd0, 20'h12345);
        prog_write(5'd1, 20'h6789A);
        prog_write(5'd2, 20'h00000);
        run_program(4, 0, -1, hs);
        checks++;
        if (hs != 2) begin
            errors++;
            $display("FAIL busy_wr_hs: got %0d want 2", hs);
        end
        prog_write(5'd1, 20'hDC1E0);
        run_program(2, -1, -1, hs);
        checks++;
        if (hs != 2) begin
            errors++;
            $display("FAIL halt_wr_hs: got %0d want 2", hs);
        end
    endtask

    task automatic test_full_program();
        int hs;
        for (int a = 0; a < 32; a++) begin
            prog_write(5'(a), 20'($urandom_range(1, 20'hFFFFF)));
        end
        run_program(-1, -1, -1, hs);
        checks++;
        if (hs != 32) begin
            errors++;
            $display("FAIL full_hs: got %0d want 32", hs);
        end
    endtask

    task automatic test_random_halt();
        int hs;
        int p;
        p = $urandom_range(1, 30);
        for (int a = 0; a < 32; a++) begin
            if (a == p) prog_write(5'(a), 20'h0);
            else prog_write(5'(a), 20'($urandom_range(1, 20'hFFFFF)));
        end
        run_program(-1, -1, -1, hs);
        checks++;
        if (hs != p) begin
            errors++;
            $display("FAIL rand_hs: got %0d want %0d", hs, p);
        end
    endtask

    task automatic test_async_reset();
        int hs;
        for (int a = 0; a < 5; a++) begin
            prog_write(5'(a), 20'($urandom_range(1, 20'hFFFFF)));
        end
        prog_write(5'd5, 20'h0);
        run_program(1, -1, 3, hs);
        run_program(-1, -1, -1, hs);
        checks++;
        if (hs != 5) begin
            errors++;
            $display("FAIL rst_rerun_hs: got %0d want 5", hs);
        end
    endtask

    initial begin
        rst        = 1'b1;
        start      = 1'b0;
        prog_we    = 1'b0;
        prog_addr  = '0;
        prog_data  = '0;
        instr_done = 1'b0;
        test_reset();
        test_basic();
        test_stall();
        test_busy_write();
        test_full_program();
        test_random_halt();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/instr_fetch_unit.md
INSTR_FETCH_UNIT -- requirements
Module: instr_fetch_unit

Interface
REQ-001 Parameter INSTR_WIDTH, 20, instruction word width; matches simple_cpu.
REQ-002 Parameter ADDR_BITS, 5, program-memory address width (32 words).
REQ-003 Port clk  input  1  single clock; all state changes on its rising edge.
REQ-004 Port rst  input  1  reset, asynchronous, active-low.
REQ-005 Port start  input  1  level-sampled; begins execution at address 0.
REQ-006 Port prog_we  input  1  program-memory write enable.
REQ-007 Port prog_addr  input  ADDR_BITS  program-memory write address.
REQ-008 Port prog_data  input  INSTR_WIDTH  program-memory write data.
REQ-009 Port instruction  output  INSTR_WIDTH  word driven to simple_cpu instruction input.
REQ-010 Port instr_valid  output  1  instruction is stable and owned by the CPU.
REQ-011 Port instr_done  input  1  one-cycle pulse from the CPU: current instruction retired.
REQ-012 Port pc  output  ADDR_BITS  address of the word being fetched or held.
REQ-013 Port busy  output  1  high in FETCH, ISSUE, WAIT.
REQ-014 Port halted  output  1  high in HALT.

Function
REQ-015 FSM states: IDLE, FETCH, ISSUE, WAIT, HALT.
REQ-016 IDLE: start=1 -> FETCH, pc<=0.
REQ-017 FETCH: memory read address = pc; unconditionally -> ISSUE.
REQ-018 ISSUE: read data 0x00000 (HALT_WORD) -> HALT, instr_valid stays 0; else instruction<=read data, instr_valid<=1, -> WAIT.
REQ-019 WAIT: instruction and instr_valid held stable until instr_done=1.
REQ-020 WAIT with instr_done=1: instr_valid<=0; pc=31 -> HALT (no wrap); else pc<=pc+1, -> FETCH.
REQ-021 Latency: instr_valid visible after the 2nd rising edge following the edge that samples start or instr_done.
REQ-022 HALT: start=1 -> pc<=0, -> FETCH; otherwise holds; instruction retains last issued word.
REQ-023 instr_done outside WAIT ignored.
REQ-024 start outside IDLE/HALT ignored.
REQ-025 prog_we honoured only in IDLE or HALT; ignored while busy=1.
REQ-026 prog_we and start in the same IDLE cycle: write completes; fetch of that address observes the new data.
REQ-027 Memory: 2^ADDR_BITS x INSTR_WIDTH, synchronous write, synchronous read (1-cycle latency), contents undefined until written.

Reset
REQ-028 rst=0 forces asynchronously: state=IDLE, pc=0, instruction=0, instr_valid=0, busy=0, halted=0.
REQ-029 Reset mid-instruction aborts it; no instr_done is required to recover.
REQ-030 Reset does not clear program memory.

Structure
REQ-031 Shared package simple_cpu_pkg: INSTR_WIDTH, ADDR_BITS, HALT_WORD, FSM state enum, instruction field positions (type [19:18], X1, X2, X3, ALU op bit 0).
REQ-032 One sub-module instr_mem: synchronous-write/synchronous-read RAM, write port from prog_*, read port from FSM.
REQ-033 FSM, pc and output register in instr_fetch_unit; no combinational path from instr_done to instruction.

Verification
REQ-034 Load addr0=0x47000, addr1=0x53000, addr2=0x00000; start; answer each valid with instr_done 3 cycles later -> instruction 0x47000 then 0x53000, pc 0 then 1, then halted=1, pc=2, instr_valid never high for addr2.
REQ-035 Program 32 nonzero words; run to completion -> 32 valid/done handshakes, halted=1 with pc=31, no wrap to 0.
REQ-036 Hold instr_done=0 for 20 cycles in WAIT -> instruction, pc, instr_valid unchanged throughout; pulse instr_done while IDLE -> no state change.
REQ-037 prog_we to addr1 (0xDC1E0) while busy -> memory unchanged; repeat in HALT then start -> 0xDC1E0 issued at pc=1.
REQ-038 Assert rst=0 asynchronously mid-WAIT at pc=3 -> outputs zero immediately, before next clk edge; release, start -> refetch from pc=0 with program intact.
